lzx_161_seq_ctrl: RTL



---
 rtl/lzx_161_ctrl_pkg.sv | 15 +
 rtl/lzx_161_seq_ctrl_if.sv | 29 ++
 rtl/lzx_74HC161.sv | 28 ++
 rtl/lzx_161_seq_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/lzx_161_ctrl_pkg.sv
// Shared types for the 74HC161 sequencing controller: FSM state encoding and run-mode constants.
// Pure declarations; no latency or backpressure of its own.
package lzx_161_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_AUTO    = 1'b1;

endpackage

// File: rtl/lzx_161_seq_ctrl_if.sv
// Control/status and counter-side bus of the 161 sequencing controller.
// master = controller side, slave = requester plus counter side; no backpressure on any signal.
interface lzx_161_seq_ctrl_if #(
    parameter int W    = 4,
    parameter int RC_W = 8
);
    logic            start;
    logic            stop;
    logic            mode;
    logic [W-1:0]    preset;
    logic            tc_in;
    logic            pe_n;
    logic            cep_n;
    logic            cet_n;
    logic [W-1:0]    d;
    logic            busy;
    logic            done;
    logic [RC_W-1:0] reload_cnt;

    modport master (
        input  start, stop, mode, preset, tc_in,
        output pe_n, cep_n, cet_n, d, busy, done, reload_cnt
    );

    modport slave (
        output start, stop, mode, preset, tc_in,
        input  pe_n, cep_n, cet_n, d, busy, done, reload_cnt
    );
endinterface

// File: rtl/lzx_74HC161.sv
// Behavioural 74HC161-style synchronous binary counter: async clear, sync load, gated count, TC.
// Q updates one CP edge after its controls; TC is combinational from Q and CET_n; no backpressure.
module lzx_74HC161 #(
    parameter int W = 4
) (
    input  logic         CP,
    input  logic         MR_n,
    input  logic         PE_n,
    input  logic         CEP_n,
    input  logic         CET_n,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC
);

    always_ff @(posedge CP or negedge MR_n) begin
        if (!MR_n) begin
            Q <= '0;
        end else if (!PE_n) begin
            Q <= D;
        end else if (!CEP_n && !CET_n) begin
            Q <= Q + W'(1);
        end
    end

    assign TC = !CET_n && (Q == {W{1'b1}});

endmodule

// File: rtl/lzx_161_seq_ctrl.sv
// Turns a start pulse into a load-then-count run of a 74HC161, one-shot or auto-reload (modulo-N).
// Reacts to TC on the same edge the counter would wrap (Mealy pe_n/cep_n); no backpressure.
module lzx_161_seq_ctrl
    import lzx_161_ctrl_pkg::*;
#(
    parameter int W    = 4,
    parameter int RC_W = 8
) (
    input  logic               CP,
    input  logic               MR,
    lzx_161_seq_ctrl_if.master bus
);

    state_t          state_q;
    state_t          state_nxt;
    logic [W-1:0]    d_q;
    logic            mode_q;
    logic [RC_W-1:0] rc_q;

    logic            pe_n_c;
    logic            cep_n_c;
    logic            cet_n_c;
    logic            accept;
    logic            rc_inc;

    // cet_n depends on state only, which keeps TC -> pe_n/cep_n free of loops.
    always_comb begin
        state_nxt = state_q;
        pe_n_c    = 1'b1;
        cep_n_c   = 1'b1;
        cet_n_c   = 1'b1;
        accept    = 1'b0;
        rc_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                pe_n_c    = 1'b0;
                state_nxt = bus.stop ? IDLE : RUN;
            end
            RUN: begin
                cet_n_c = 1'b0;
                cep_n_c = 1'b0;
                if (bus.stop) begin
                    cep_n_c   = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.tc_in) begin
                    if (mode_q == MODE_AUTO) begin
                        // Reload instead of wrapping to zero.
                        pe_n_c = 1'b0;
                        rc_inc = 1'b1;
                    end else begin
                        cep_n_c   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q <= IDLE;
            d_q     <= '0;
            mode_q  <= MODE_ONESHOT;
            rc_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                d_q    <= bus.preset;
                mode_q <= bus.mode;
                rc_q   <= '0;
            end else if (rc_inc && (rc_q != {RC_W{1'b1}})) begin
                rc_q <= rc_q + RC_W'(1);
            end
        end
    end

    assign bus.pe_n       = pe_n_c;
    assign bus.cep_n      = cep_n_c;
    assign bus.cet_n      = cet_n_c;
    assign bus.d          = d_q;
    assign bus.busy       = (state_q == LOAD) || (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.reload_cnt = rc_q;

endmodule
